// File: rtl/zone_scheduler.sv
// Round-robin arbiter sharing one heater/cooler plant between N_ZONES thermostats; ZONE0_PRIO_EN gives zone 0 precedence in IDLE.
// Latency: request sampled at edge E drives grant/heat_en/cool_en from edge E; all outputs registered, no input-to-output paths.
// Backpressure: none; requests are levels, held grants last >= MIN_ON cycles and each release is followed by GUARD rest cycles.
module zone_scheduler #(
    parameter int N_ZONES = 4,
    parameter int MIN_ON  = 8,
    parameter int GUARD   = 2,
    localparam int ZW     = $clog2(N_ZONES)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_ZONES-1:0] req_heat,
    input  logic [N_ZONES-1:0] req_cool,
    output logic [N_ZONES-1:0] grant,
    output logic               heat_en,
    output logic               cool_en,
    output logic [ZW-1:0]      zone_id,
    output logic               busy
);

    localparam int DW = $clog2(MIN_ON) + 1;
    localparam int GW = $clog2(GUARD) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GUARD} state_t;

    state_t             state_q, state_d;
    logic [ZW-1:0]      ptr_q, ptr_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [N_ZONES-1:0] grant_d;
    logic               heat_d, cool_d, busy_d;
    logic [ZW-1:0]      zone_d;

    logic [N_ZONES-1:0] vh, vc, v;
    logic               found, still, keep;
    logic [ZW-1:0]      sel, idx;

    // A zone asking for both heat and cool is treated as idle.
    assign vh = req_heat & ~req_cool;
    assign vc = req_cool & ~req_heat;
    assign v  = vh | vc;

    // heat_en doubles as the latched mode and zone_id as the latched zone while in RUN.
    assign still = heat_en ? vh[zone_id] : vc[zone_id];
    assign keep  = still && !(|(v & ~grant));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        gcnt_d  = gcnt_q;
        grant_d = grant;
        heat_d  = heat_en;
        cool_d  = cool_en;
        zone_d  = zone_id;
        busy_d  = busy;
        found   = 1'b0;
        sel     = '0;
        idx     = '0;

        for (int k = 0; k < N_ZONES; k++) begin
            idx = ZW'((int'(ptr_q) + k) % N_ZONES);
            if (!found && v[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
`ifdef ZONE0_PRIO_EN
        if (v[0]) begin
            found = 1'b1;
            sel   = '0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_RUN;
                    grant_d = {{(N_ZONES-1){1'b0}}, 1'b1} << sel;
                    heat_d  = vh[sel];
                    cool_d  = ~vh[sel];
                    zone_d  = sel;
                    busy_d  = 1'b1;
                    dwell_d = DW'(MIN_ON - 1);
                end
            end
            ST_RUN: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DW'(1);
                end else if (!keep) begin
                    state_d = ST_GUARD;
                    grant_d = '0;
                    heat_d  = 1'b0;
                    cool_d  = 1'b0;
                    zone_d  = '0;
                    busy_d  = 1'b1;
                    ptr_d   = (zone_id == ZW'(N_ZONES - 1)) ? '0 : zone_id + ZW'(1);
                    gcnt_d  = GW'(GUARD - 1);
                end
            end
            ST_GUARD: begin
                if (gcnt_q != '0) begin
                    gcnt_d = gcnt_q - GW'(1);
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                heat_d  = 1'b0;
                cool_d  = 1'b0;
                zone_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            dwell_q <= '0;
            gcnt_q  <= '0;
            grant   <= '0;
            heat_en <= 1'b0;
            cool_en <= 1'b0;
            zone_id <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            gcnt_q  <= gcnt_d;
            grant   <= grant_d;
            heat_en <= heat_d;
            cool_en <= cool_d;
            zone_id <= zone_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_zone_scheduler.sv
// Scoreboard bench for zone_scheduler: stimulus queues expected grants, a negedge monitor checks each grant, its length, the gap and the guard.
module tb_zone_scheduler;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req_heat, req_cool;
    logic [3:0] grant;
    logic       heat_en, cool_en, busy;
    logic [1:0] zone_id;

    int checks   = 0;
    int failures = 0;

    zone_scheduler #(.N_ZONES(4), .MIN_ON(8), .GUARD(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req_heat(req_heat),
        .req_cool(req_cool),
        .grant   (grant),
        .heat_en (heat_en),
        .cool_en (cool_en),
        .zone_id (zone_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic       h;
        logic       c;
        logic [1:0] z;
        int         len;   // 0: length not checked
        int         gap;   // -1: gap not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic h, input logic c,
                        input logic [1:0] z, input int len, input int gap);
        exp_t e;
        e.g = g; e.h = h; e.c = c; e.z = z; e.len = len; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        tick(2);
        for (k = 0; k < 200; k++) begin
            if (!busy) break;
            tick(1);
        end
        chk("idle_timeout", busy, 0);
        tick(1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor
    logic [3:0] pg;
    int         len_cnt, gap_cnt, grd_cnt;
    bit         in_grd;

    always @(negedge clk) begin
        if (!rstn) begin
            pg      = '0;
            len_cnt = 0;
            gap_cnt = -1;
            grd_cnt = 0;
            in_grd  = 0;
        end else begin
            chk("heat_cool_excl", heat_en & cool_en, 0);
            if (grant != 0 && pg == 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", grant, 0);
                    cur.len = 0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant", grant, cur.g);
                    chk("heat_en", heat_en, cur.h);
                    chk("cool_en", cool_en, cur.c);
                    chk("zone_id", zone_id, cur.z);
                    chk("busy_run", busy, 1);
                    if (cur.gap >= 0) chk("gap", gap_cnt, cur.gap);
                end
                len_cnt = 1;
                in_grd  = 0;
            end else if (grant != 0) begin
                if (grant != pg) chk("grant_stable", grant, pg);
                len_cnt++;
            end else if (pg != 0) begin
                if (cur.len > 0) chk("grant_len", len_cnt, cur.len);
                gap_cnt = 1;
                in_grd  = 1;
                grd_cnt = busy ? 1 : 0;
            end else begin
                if (gap_cnt >= 0) gap_cnt++;
                if (in_grd) begin
                    if (busy) grd_cnt++;
                    else begin
                        chk("guard_len", grd_cnt, 2);
                        in_grd = 0;
                    end
                end
            end
            pg = grant;
        end
    end

    initial begin
        rstn     = 1'b0;
        req_heat = 4'b1111;
        req_cool = 4'b0000;

        // Reset state with all zones requesting, then one-edge latency after release
        tick(3);
        chk("rst_grant", grant, 0);
        chk("rst_heat", heat_en, 0);
        chk("rst_cool", cool_en, 0);
        chk("rst_zone", zone_id, 0);
        chk("rst_busy", busy, 0);
        push(4'b0001, 1, 0, 0, 8, -1);
        #2 rstn = 1'b1;
        tick(1);
        chk("lat_grant", grant, 4'b0001);
        chk("lat_heat", heat_en, 1);
        chk("lat_zone", zone_id, 0);
        req_heat = 4'b0000;
        wait_idle();

        // Sole requester held 30 cycles
        req_heat = 4'b0100;
        push(4'b0100, 1, 0, 2, 30, -1);
        tick(30);
        req_heat = 4'b0000;
        wait_idle();

        // One-cycle cool pulse still gets MIN_ON
        req_cool = 4'b0010;
        push(4'b0010, 0, 1, 1, 8, -1);
        tick(1);
        req_cool = 4'b0000;
        wait_idle();

        // Round-robin from ptr=0 with all zones heating
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        req_heat = 4'b1111;
        push(4'b0001, 1, 0, 0, 8, -1);
        push(4'b0010, 1, 0, 1, 8, 3);
        push(4'b0100, 1, 0, 2, 8, 3);
        push(4'b1000, 1, 0, 3, 8, 3);
        push(4'b0001, 1, 0, 0, 8, 3);
        tick(46);
        req_heat = 4'b0000;
        wait_idle();

        // Conflicting request is ignored; a valid cool request then wins
        req_heat = 4'b1000;
        req_cool = 4'b1000;
        tick(20);
        chk("conflict_grant", grant, 0);
        chk("conflict_busy", busy, 0);
        req_cool = 4'b1010;
        push(4'b0010, 0, 1, 1, 8, -1);
        tick(1);
        chk("conflict_cool_en", cool_en, 1);
        tick(2);
        req_heat = 4'b0000;
        req_cool = 4'b0000;
        wait_idle();

        // Mode change heat->cool forces release, guard, then cool re-grant
        req_heat = 4'b0100;
        push(4'b0100, 1, 0, 2, 12, -1);
        push(4'b0100, 0, 1, 2, 8, 3);
        tick(12);
        req_heat = 4'b0000;
        req_cool = 4'b0100;
        tick(8);
        req_cool = 4'b0000;
        wait_idle();

        // Asynchronous reset mid-RUN clears outputs immediately
        req_heat = 4'b1000;
        push(4'b1000, 1, 0, 3, 0, -1);
        tick(3);
        rstn = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_heat", heat_en, 0);
        chk("arst_zone", zone_id, 0);
        chk("arst_busy", busy, 0);
        req_heat = 4'b0000;
        tick(1);
        rstn = 1'b1;
        tick(1);

        // Zone 0 just served (ptr=1), then zones 0 and 1 both valid
        req_heat = 4'b0001;
        push(4'b0001, 1, 0, 0, 8, -1);
        tick(1);
        req_heat = 4'b0000;
        wait_idle();
        req_heat = 4'b0011;
`ifdef ZONE0_PRIO_EN
        push(4'b0001, 1, 0, 0, 8, -1);
`else
        push(4'b0010, 1, 0, 1, 8, -1);
`endif
        tick(2);
        req_heat = 4'b0000;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zone_scheduler.md
# zone_scheduler

Shares the incubator's single heater/cooler plant between several chambers (zones), each running its own thermostat that raises a heat or cool request. Round-robin arbiter with compressor protection: a grant holds at least MIN_ON cycles, and a GUARD rest period follows every release. Sits between the per-zone thermostat FSMs and the shared actuator drivers (heater, cooler, CRS fan path).

## Interface
- N_ZONES, 4, number of requesting zones (2..8)
- MIN_ON, 8, minimum grant length in cycles (>=1)
- GUARD, 2, actuator-off rest after each release in cycles (>=1)
- ZW, $clog2(N_ZONES), zone index width (derived)

- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_heat  in  N_ZONES  per-zone heat request, level
- req_cool  in  N_ZONES  per-zone cool request, level
- grant  out  N_ZONES  one-hot granted zone; all-zero when none
- heat_en  out  1  shared heater drive
- cool_en  out  1  shared cooler drive
- zone_id  out  ZW  index of granted zone; 0 when none
- busy  out  1  high in RUN or GUARD

## Operation
- Registered Moore outputs. Reset values: grant=0, heat_en=0, cool_en=0, zone_id=0, busy=0, state=IDLE, ptr=0, counters=0.
- A zone is valid-heat if req_heat[i]&~req_cool[i], and valid-cool if req_cool[i]&~req_heat[i]. If both bits are set, the zone is treated as not requesting.
- IDLE:
  - Search valid zones starting at ptr, wrapping modulo N_ZONES. The first hit wins.
  - Latch zone and mode (heat wins only if valid-heat, else cool), load dwell=MIN_ON-1, go RUN.
  - With no valid zone, remain in IDLE.
- RUN:
  - grant[zone]=1 and zone_id=zone. heat_en or cool_en follows the latched mode; never both. busy=1.
  - While dwell>0, decrement each cycle. Requests are ignored, so a dropped request still gets the full MIN_ON.
  - At dwell==0, evaluate every cycle:
    - Stay while the granted zone is still valid in the latched mode and no other zone is valid.
    - Otherwise release: set ptr=(zone+1) mod N_ZONES, load gcnt=GUARD-1, go GUARD.
  - A mode change in the granted zone (heat->cool) counts as a drop. There is never a direct heat-to-cool switch without GUARD.
- GUARD: all actuator outputs and grant are 0, busy=1. Decrement gcnt; at gcnt==0 go IDLE.
- Reset asserted mid-RUN/GUARD clears all outputs asynchronously and returns to IDLE with ptr=0.

## Timing
- Request sampled at edge E in IDLE -> grant/heat_en/cool_en high from edge E onward (one-edge latency).
- Grant length is at least MIN_ON cycles. After release, outputs are low for GUARD cycles (GUARD) plus 1 cycle (IDLE), so the minimum gap between grants is GUARD+1 cycles.
- Fairness: with all zones continuously valid, each zone is served within N_ZONES*(MIN_ON+GUARD+1) cycles.
- grant, zone_id, heat_en and cool_en change on the same edge. There are no combinational paths from inputs to outputs.

## Configuration
- ZONE0_PRIO_EN defined: in IDLE, zone 0 wins whenever it is valid, regardless of ptr. Other zones use round-robin from ptr. Zone 0 does not preempt a running grant; it wins only at the next IDLE. Zone 0 is the alarm/sample chamber.
- Not defined: pure round-robin for all zones.

## Test plan
- Reset: hold rstn=0 with req_heat=4'b1111 -> all outputs 0. Release -> next edge grant=4'b0001, heat_en=1, zone_id=0.
- Sole requester: req_heat[2]=1 held 30 cycles -> grant=4'b0100 and heat_en=1 continuously; busy=1. Drop the request -> release one cycle later, then 2 GUARD cycles with outputs 0.
- Minimum on: 1-cycle pulse on req_cool[1] -> cool_en=1 for exactly 8 cycles, 2 cycles all-off with busy=1, then busy=0.
- Round-robin: all four zones hold req_heat -> grants 0,1,2,3,0 in order, each 8 cycles, separated by 3 cycles of grant=0.
- Conflict and mode change:
  - req_heat[3]=req_cool[3]=1 alone -> no grant for 20 cycles. Add req_cool[1] -> zone 1 granted with cool_en.
  - Granted zone switching heat->cool after dwell -> release, GUARD, then re-grant with cool_en=1. heat_en and cool_en are never high together.
- Priority macro: zone 0 just served (ptr=1), zones 0 and 1 valid. With ZONE0_PRIO_EN -> zone 0 granted. Without -> zone 1 granted.
